// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t      : 32-bit architectural data word
//   regbits_t   : 5-bit register index
//   wbq_entry_t : one writeback-queue slot {sel, dat}
//   WBQ_DEPTH   : default writeback-queue depth
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        regbits_t sel;
        word_t    dat;
    } wbq_entry_t;

    localparam int unsigned WBQ_DEPTH = 4;

endpackage

// File: rtl/regfile_writeback_queue.sv
// Register-file writeback queue. Merges load (older) and ALU (younger)
// writeback requests into a FIFO and retires one entry per cycle to the
// register file, preserving program order.
// Ports:
//   CLK, nRST              : clock, synchronous active-low reset
//   mem_valid/sel/dat      : load writeback request;  mem_ready accepts it
//   alu_valid/sel/dat      : ALU writeback request;   alu_ready accepts it
//   WEN, wsel, wdat        : registered register-file write port
//   rsel1, rsel2           : decode-stage source registers
//   stall                  : a pending or in-flight write targets rsel1/rsel2
module regfile_writeback_queue
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     mem_valid,
    input  regbits_t mem_sel,
    input  word_t    mem_dat,
    output logic     mem_ready,
    input  logic     alu_valid,
    input  regbits_t alu_sel,
    input  word_t    alu_dat,
    output logic     alu_ready,
    output logic     WEN,
    output regbits_t wsel,
    output word_t    wdat,
    input  regbits_t rsel1,
    input  regbits_t rsel2,
    output logic     stall
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wbq_entry_t       fifo [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] alu_slot;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic             mem_enq;
    logic             alu_enq;
    logic             deq;

    // Free space is taken from the count before this cycle's dequeue, so the
    // readies never depend on the outgoing write.
    assign free = CNT_W'(DEPTH) - count;

    always_comb begin
        mem_ready = (free >= CNT_W'(1));
        // A live load request claims a slot first; ALU then needs a second one.
        if (mem_valid && (mem_sel != '0)) begin
            alu_ready = (free >= CNT_W'(2));
        end else begin
            alu_ready = (free >= CNT_W'(1));
        end
    end

    // Writes to register 0 are accepted but dropped.
    assign mem_enq  = mem_valid && mem_ready && (mem_sel != '0);
    assign alu_enq  = alu_valid && alu_ready && (alu_sel != '0);
    assign deq      = (count != '0);
    assign alu_slot = wr_ptr + PTR_W'(mem_enq);

    always_ff @(posedge CLK) begin
        if (mem_enq) begin
            fifo[wr_ptr] <= '{sel: mem_sel, dat: mem_dat};
        end
        if (alu_enq) begin
            fifo[alu_slot] <= '{sel: alu_sel, dat: alu_dat};
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            WEN    <= 1'b0;
            wsel   <= '0;
            wdat   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(mem_enq) + PTR_W'(alu_enq);
            count  <= count + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(deq);
            if (deq) begin
                WEN    <= 1'b1;
                wsel   <= fifo[rd_ptr].sel;
                wdat   <= fifo[rd_ptr].dat;
                rd_ptr <= rd_ptr + PTR_W'(1);
            end else begin
                WEN <= 1'b0;
            end
        end
    end

    // Hazard window covers every queued entry plus the write on the port now.
    always_comb begin
        stall = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if ((rsel1 != '0) && (fifo[rd_ptr + PTR_W'(i)].sel == rsel1)) begin
                    stall = 1'b1;
                end
                if ((rsel2 != '0) && (fifo[rd_ptr + PTR_W'(i)].sel == rsel2)) begin
                    stall = 1'b1;
                end
            end
        end
        if (WEN && (rsel1 != '0) && (wsel == rsel1)) begin
            stall = 1'b1;
        end
        if (WEN && (rsel2 != '0) && (wsel == rsel2)) begin
            stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_regfile_writeback_queue;
    import cpu_types_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic     CLK = 1'b0;
    logic     nRST = 1'b0;
    logic     mem_valid = 1'b0;
    regbits_t mem_sel = '0;
    word_t    mem_dat = '0;
    logic     mem_ready;
    logic     alu_valid = 1'b0;
    regbits_t alu_sel = '0;
    word_t    alu_dat = '0;
    logic     alu_ready;
    logic     WEN;
    regbits_t wsel;
    word_t    wdat;
    regbits_t rsel1 = '0;
    regbits_t rsel2 = '0;
    logic     stall;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 CLK = ~CLK;

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .mem_valid (mem_valid),
        .mem_sel   (mem_sel),
        .mem_dat   (mem_dat),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_sel   (alu_sel),
        .alu_dat   (alu_dat),
        .alu_ready (alu_ready),
        .WEN       (WEN),
        .wsel      (wsel),
        .wdat      (wdat),
        .rsel1     (rsel1),
        .rsel2     (rsel2),
        .stall     (stall)
    );

    // Reference model: pending writes in program order plus the last write.
    wbq_entry_t model_q[$];
    logic       m_wen  = 1'b0;
    regbits_t   m_wsel = '0;
    word_t      m_wdat = '0;

    function automatic int unsigned m_free();
        return DEPTH - model_q.size();
    endfunction

    function automatic logic m_mem_ready();
        return m_free() >= 1;
    endfunction

    function automatic logic m_alu_ready();
        if (mem_valid && mem_sel != 0) return m_free() >= 2;
        return m_free() >= 1;
    endfunction

    function automatic logic m_stall(input regbits_t r);
        if (r == 0) return 1'b0;
        if (m_wen && m_wsel == r) return 1'b1;
        foreach (model_q[i]) if (model_q[i].sel == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge: model acceptance, dequeue and enqueue, then settle.
    task automatic tick();
        logic take_mem, take_alu;
        wbq_entry_t em, ea, hd;
        take_mem = nRST && mem_valid && m_mem_ready() && (mem_sel != 0);
        take_alu = nRST && alu_valid && m_alu_ready() && (alu_sel != 0);
        em = '{sel: mem_sel, dat: mem_dat};
        ea = '{sel: alu_sel, dat: alu_dat};
        @(posedge CLK);
        if (!nRST) begin
            model_q.delete();
            m_wen = 1'b0; m_wsel = '0; m_wdat = '0;
        end else begin
            if (model_q.size() > 0) begin
                hd = model_q.pop_front();
                m_wen = 1'b1; m_wsel = hd.sel; m_wdat = hd.dat;
            end else begin
                m_wen = 1'b0;
            end
            if (take_mem) model_q.push_back(em);
            if (take_alu) model_q.push_back(ea);
        end
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_sel = '0; mem_dat = '0;
        alu_valid = 1'b0; alu_sel = '0; alu_dat = '0;
        rsel1 = '0; rsel2 = '0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < int'(DEPTH) + 2; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        n_total++; if (WEN !== 1'b0) $display("FAIL reset_wen: got %b want 0", WEN); else n_pass++;
        n_total++; if (wsel !== 5'd0) $display("FAIL reset_wsel: got %0d want 0", wsel); else n_pass++;
        n_total++; if (wdat !== 32'd0) $display("FAIL reset_wdat: got %h want 0", wdat); else n_pass++;
        mem_valid = 1'b1; mem_sel = 5'd1; alu_valid = 1'b1; alu_sel = 5'd2; rsel1 = 5'd1; rsel2 = 5'd2;
        #1;
        n_total++; if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready: got %b want 1", mem_ready); else n_pass++;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready: got %b want 1", alu_ready); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_single_write();
        alu_valid = 1'b1; alu_sel = 5'd5; alu_dat = 32'hDEADBEEF;
        #1;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL single_alu_ready: got %b want 1", alu_ready); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (WEN !== 1'b0) $display("FAIL single_wen_early: got %b want 0", WEN); else n_pass++;
        tick();
        n_total++; if (WEN !== 1'b1) $display("FAIL single_wen: got %b want 1", WEN); else n_pass++;
        n_total++; if (wsel !== 5'd5) $display("FAIL single_wsel: got %0d want 5", wsel); else n_pass++;
        n_total++; if (wdat !== 32'hDEADBEEF) $display("FAIL single_wdat: got %h want deadbeef", wdat); else n_pass++;
        tick();
        n_total++; if (WEN !== 1'b0) $display("FAIL single_wen_once: got %b want 0", WEN); else n_pass++;
    endtask

    task automatic test_ordering();
        mem_valid = 1'b1; mem_sel = 5'd3; mem_dat = 32'h11;
        alu_valid = 1'b1; alu_sel = 5'd3; alu_dat = 32'h22;
        #1;
        n_total++; if (mem_ready !== 1'b1) $display("FAIL order_mem_ready: got %b want 1", mem_ready); else n_pass++;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL order_alu_ready: got %b want 1", alu_ready); else n_pass++;
        tick();
        idle_inputs();
        tick();
        n_total++; if ({WEN, wsel, wdat} !== {1'b1, 5'd3, 32'h11})
            $display("FAIL order_first: got wen=%b sel=%0d dat=%h want wen=1 sel=3 dat=11", WEN, wsel, wdat); else n_pass++;
        tick();
        n_total++; if ({WEN, wsel, wdat} !== {1'b1, 5'd3, 32'h22})
            $display("FAIL order_second: got wen=%b sel=%0d dat=%h want wen=1 sel=3 dat=22", WEN, wsel, wdat); else n_pass++;
        tick();
        n_total++; if (WEN !== 1'b0) $display("FAIL order_done: got %b want 0", WEN); else n_pass++;
    endtask

    task automatic test_zero_reg();
        alu_valid = 1'b1; alu_sel = 5'd0; alu_dat = 32'hCAFE0000;
        #1;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL zero_alu_ready: got %b want 1", alu_ready); else n_pass++;
        tick();
        idle_inputs();
        tick();
        n_total++; if (WEN !== 1'b0) $display("FAIL zero_no_write: got %b want 0", WEN); else n_pass++;
        // A real request now must be the only thing in the queue.
        alu_valid = 1'b1; alu_sel = 5'd9; alu_dat = 32'h99;
        tick();
        idle_inputs();
        tick();
        n_total++; if ({WEN, wsel, wdat} !== {1'b1, 5'd9, 32'h99})
            $display("FAIL zero_next: got wen=%b sel=%0d dat=%h want wen=1 sel=9 dat=99", WEN, wsel, wdat); else n_pass++;
        tick();
        n_total++; if (WEN !== 1'b0) $display("FAIL zero_count: got %b want 0", WEN); else n_pass++;
    endtask

    task automatic test_full();
        int unsigned writes;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_sel = regbits_t'(1 + i); mem_dat = 32'h100 + i;
            alu_valid = 1'b1; alu_sel = regbits_t'(9 + i); alu_dat = 32'h200 + i;
            #1;
            n_total++; if (mem_ready !== m_mem_ready())
                $display("FAIL full_mem_ready[%0d]: got %b want %b", i, mem_ready, m_mem_ready()); else n_pass++;
            n_total++; if (alu_ready !== m_alu_ready())
                $display("FAIL full_alu_ready[%0d]: got %b want %b", i, alu_ready, m_alu_ready()); else n_pass++;
            tick();
            n_total++; if ({WEN, wsel, wdat} !== {m_wen, m_wsel, m_wdat})
                $display("FAIL full_write[%0d]: got wen=%b sel=%0d dat=%h want wen=%b sel=%0d dat=%h",
                         i, WEN, wsel, wdat, m_wen, m_wsel, m_wdat); else n_pass++;
        end
        idle_inputs();
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_wen) writes++;
            n_total++; if ({WEN, wsel, wdat} !== {m_wen, m_wsel, m_wdat})
                $display("FAIL full_drain[%0d]: got wen=%b sel=%0d dat=%h want wen=%b sel=%0d dat=%h",
                         i, WEN, wsel, wdat, m_wen, m_wsel, m_wdat); else n_pass++;
        end
        n_total++; if (WEN !== 1'b0) $display("FAIL full_empty: got %b want 0", WEN); else n_pass++;
    endtask

    task automatic test_hazard_reset();
        alu_valid = 1'b1; alu_sel = 5'd7; alu_dat = 32'h77;
        tick();
        idle_inputs();
        rsel1 = 5'd7;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL hazard_stall: got %b want 1", stall); else n_pass++;
        rsel1 = 5'd0;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL hazard_zero: got %b want 0", stall); else n_pass++;
        rsel2 = 5'd7;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL hazard_rsel2: got %b want 1", stall); else n_pass++;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        rsel1 = 5'd7; rsel2 = 5'd7;
        #1;
        n_total++; if (WEN !== 1'b0) $display("FAIL hrst_wen: got %b want 0", WEN); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL hrst_stall: got %b want 0", stall); else n_pass++;
        tick();
        n_total++; if (WEN !== 1'b0) $display("FAIL hrst_no_write: got %b sel=%0d want 0", WEN, wsel); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            nRST      = ($urandom_range(0, 59) != 0);
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_sel   = regbits_t'($urandom_range(0, 7));
            mem_dat   = $urandom;
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_sel   = regbits_t'($urandom_range(0, 7));
            alu_dat   = $urandom;
            rsel1     = regbits_t'($urandom_range(0, 7));
            rsel2     = regbits_t'($urandom_range(0, 7));
            #1;
            n_total++; if (stall !== (m_stall(rsel1) || m_stall(rsel2)))
                $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, m_stall(rsel1) || m_stall(rsel2)); else n_pass++;
            if (nRST) begin
                n_total++; if (mem_ready !== m_mem_ready())
                    $display("FAIL rand_mem_ready[%0d]: got %b want %b", i, mem_ready, m_mem_ready()); else n_pass++;
                n_total++; if (alu_ready !== m_alu_ready())
                    $display("FAIL rand_alu_ready[%0d]: got %b want %b", i, alu_ready, m_alu_ready()); else n_pass++;
            end
            tick();
            n_total++; if ({WEN, wsel, wdat} !== {m_wen, m_wsel, m_wdat})
                $display("FAIL rand_write[%0d]: got wen=%b sel=%0d dat=%h want wen=%b sel=%0d dat=%h",
                         i, WEN, wsel, wdat, m_wen, m_wsel, m_wdat); else n_pass++;
        end
        nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_write();
        drain();
        test_ordering();
        drain();
        test_zero_reg();
        drain();
        test_full();
        drain();
        test_hazard_reset();
        drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
